// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned products into a widened accumulator and emits each total on a valid/ready port
module product_accumulator #(
  parameter int N = 8,
  parameter int LEN = 4,
  parameter int GUARD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*N-1:0]        z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N+GUARD-1:0]  sum,
  output logic                  ovf
);
  localparam int ACC_W = 2*N + GUARD;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_sum;
  logic [7:0] cnt_q, cnt_d;
  logic ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, out_valid_q, out_valid_d, carry, accept, last;
  assign {carry, acc_sum} = {1'b0, acc_q} + (ACC_W+1)'(z);
  assign in_ready = state_q != HOLD;
  assign accept = in_valid && in_ready;
  assign last = cnt_q == 8'(LEN-1);
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_acc_d = ovf_acc_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    if (state_q == HOLD) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
    end else if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_acc_d = 1'b0;
      state_d = IDLE;
    end else if (accept) begin
      acc_d = last ? '0 : acc_sum;
      cnt_d = last ? '0 : cnt_q + 8'd1;
      ovf_acc_d = last ? 1'b0 : ovf_acc_q | carry;
      state_d = last ? HOLD : ACCUM;
      sum_d = last ? acc_sum : sum_q;
      ovf_d = last ? ovf_acc_q | carry : ovf_q;
      out_valid_d = last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_acc_q <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks on three configurations (LEN=4/GUARD=2, LEN=4/GUARD=1, LEN=1/GUARD=2)
module tb_product_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic rst0, clr0, iv0, ir0, ov0, or0, ovf0;
  logic [7:0] z0;
  logic [9:0] sum0;
  logic rst1, clr1, iv1, ir1, ov1, or1, ovf1;
  logic [7:0] z1;
  logic [8:0] sum1;
  logic rst2, clr2, iv2, ir2, ov2, or2, ovf2;
  logic [7:0] z2;
  logic [9:0] sum2;
  product_accumulator #(.N(4), .LEN(4), .GUARD(2)) u0 (.clk(clk), .rst(rst0), .clear(clr0), .in_valid(iv0), .in_ready(ir0), .z(z0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .ovf(ovf0));
  product_accumulator #(.N(4), .LEN(4), .GUARD(1)) u1 (.clk(clk), .rst(rst1), .clear(clr1), .in_valid(iv1), .in_ready(ir1), .z(z1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .ovf(ovf1));
  product_accumulator #(.N(4), .LEN(1), .GUARD(2)) u2 (.clk(clk), .rst(rst2), .clear(clr2), .in_valid(iv2), .in_ready(ir2), .z(z2), .out_valid(ov2), .out_ready(or2), .sum(sum2), .ovf(ovf2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push0(input logic [7:0] v);
    iv0 = 1'b1;
    z0 = v;
    tick();
    iv0 = 1'b0;
  endtask
  task automatic push1(input logic [7:0] v);
    iv1 = 1'b1;
    z1 = v;
    tick();
    iv1 = 1'b0;
  endtask
  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
    z0 = 8'd77; z1 = 8'd77; z2 = 8'd77;
    tick();
    tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    n_cmp++; if (sum0 !== 10'd0) begin n_bad++; $display("FAIL reset_sum: got %0d want 0", sum0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_len1: got %b want 0", ov2); end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    tick();
    n_cmp++; if (ir0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_no_capture: got %b want 0", ov0); end
  endtask
  task automatic test_basic_sum();
    or0 = 1'b1;
    push0(8'd3);
    push0(8'd5);
    push0(8'd7);
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", ov0); end
    push0(8'd9);
    n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", ov0); end
    n_cmp++; if (sum0 !== 10'd24) begin n_bad++; $display("FAIL basic_sum: got %0d want 24", sum0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf0); end
    n_cmp++; if (ir0 !== 1'b0) begin n_bad++; $display("FAIL basic_ready_hold: got %b want 0", ir0); end
    tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", ov0); end
    n_cmp++; if (ir0 !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b want 1", ir0); end
  endtask
  task automatic test_backpressure();
    or0 = 1'b0;
    push0(8'd225);
    z0 = 8'd99;
    tick();
    push0(8'd225);
    tick();
    tick();
    n_cmp++; if (ir0 !== 1'b1 || ov0 !== 1'b0) begin n_bad++; $display("FAIL bp_bubble: got ready=%b valid=%b want ready=1 valid=0", ir0, ov0); end
    push0(8'd225);
    z0 = 8'd99;
    tick();
    push0(8'd225);
    iv0 = 1'b1;
    z0 = 8'd5;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ov0 !== 1'b1 || sum0 !== 10'd900 || ir0 !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b sum=%0d ready=%b want valid=1 sum=900 ready=0", i, ov0, sum0, ir0); end
      tick();
    end
    n_cmp++; if (ov0 !== 1'b1 || sum0 !== 10'd900 || ovf0 !== 1'b0) begin n_bad++; $display("FAIL bp_final: got valid=%b sum=%0d ovf=%b want 1/900/0", ov0, sum0, ovf0); end
    iv0 = 1'b0;
    or0 = 1'b1;
    tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", ov0); end
  endtask
  task automatic test_clear();
    or0 = 1'b0;
    push0(8'd10);
    push0(8'd20);
    clr0 = 1'b1;
    iv0 = 1'b1;
    z0 = 8'd30;
    tick();
    clr0 = 1'b0;
    iv0 = 1'b0;
    push0(8'd1);
    push0(8'd2);
    push0(8'd3);
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL clear_count_reset: got %b want 0", ov0); end
    push0(8'd4);
    n_cmp++; if (ov0 !== 1'b1 || sum0 !== 10'd10 || ovf0 !== 1'b0) begin n_bad++; $display("FAIL clear_sum: got valid=%b sum=%0d ovf=%b want 1/10/0", ov0, sum0, ovf0); end
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    n_cmp++; if (ov0 !== 1'b1 || sum0 !== 10'd10) begin n_bad++; $display("FAIL clear_in_hold: got valid=%b sum=%0d want 1/10", ov0, sum0); end
    or0 = 1'b1;
    tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL clear_release: got %b want 0", ov0); end
  endtask
  task automatic test_overflow();
    or1 = 1'b1;
    push1(8'd225);
    push1(8'd225);
    push1(8'd225);
    push1(8'd225);
    n_cmp++; if (ov1 !== 1'b1 || sum1 !== 9'd388) begin n_bad++; $display("FAIL ovf_sum: got valid=%b sum=%0d want 1/388", ov1, sum1); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf1); end
    tick();
    push1(8'd1);
    push1(8'd1);
    push1(8'd1);
    push1(8'd1);
    n_cmp++; if (ov1 !== 1'b1 || sum1 !== 9'd4 || ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_next: got valid=%b sum=%0d ovf=%b want 1/4/0", ov1, sum1, ovf1); end
    tick();
  endtask
  task automatic test_len1_and_rst();
    or2 = 1'b0;
    iv2 = 1'b1;
    z2 = 8'd15;
    tick();
    n_cmp++; if (ov2 !== 1'b1 || sum2 !== 10'd15 || ir2 !== 1'b0) begin n_bad++; $display("FAIL len1_first: got valid=%b sum=%0d ready=%b want 1/15/0", ov2, sum2, ir2); end
    z2 = 8'd40;
    tick();
    n_cmp++; if (ov2 !== 1'b1 || sum2 !== 10'd15) begin n_bad++; $display("FAIL len1_hold: got valid=%b sum=%0d want 1/15", ov2, sum2); end
    iv2 = 1'b0;
    or2 = 1'b1;
    tick();
    n_cmp++; if (ov2 !== 1'b0 || ir2 !== 1'b1) begin n_bad++; $display("FAIL len1_release: got valid=%b ready=%b want 0/1", ov2, ir2); end
    or2 = 1'b0;
    iv2 = 1'b1;
    z2 = 8'd7;
    tick();
    iv2 = 1'b0;
    n_cmp++; if (ov2 !== 1'b1 || sum2 !== 10'd7) begin n_bad++; $display("FAIL len1_second: got valid=%b sum=%0d want 1/7", ov2, sum2); end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    n_cmp++; if (ov2 !== 1'b0 || sum2 !== 10'd0) begin n_bad++; $display("FAIL rst_hold: got valid=%b sum=%0d want 0/0", ov2, sum2); end
    or2 = 1'b1;
    tick();
    tick();
    n_cmp++; if (ov2 !== 1'b0 || ir2 !== 1'b1) begin n_bad++; $display("FAIL rst_discard: got valid=%b ready=%b want 0/1", ov2, ir2); end
  endtask
  initial begin
    test_reset();
    test_basic_sum();
    test_backpressure();
    test_clear();
    test_overflow();
    test_len1_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
